// File: rtl/softmax_seq_pkg.sv
// softmax_seq_pkg
//   Shared definitions for the softmax sequencer: the FSM state encoding and
//   the default datapath latencies used as parameter defaults by the top.
package softmax_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      MAX_RD,
      MAX_DRAIN,
      SUB_RD,
      SUM_DRAIN,
      LOG,
      OUT_RD,
      OUT_DRAIN,
      DONE
   } state_t;

   localparam int DEF_ADDRSIZE = 8;
   localparam int DEF_RD_LAT   = 1;
   localparam int DEF_MAX_LAT  = 2;
   localparam int DEF_EXP_LAT  = 1;
   localparam int DEF_SUM_LAT  = 2;
   localparam int DEF_LN_LAT   = 1;
   localparam int DEF_OUT_LAT  = 3;
   localparam int DEF_CW       = 4;

endpackage

// File: rtl/softmax_vld_delay.sv
// softmax_vld_delay
//   Fixed-depth shift register used to align a read-valid with the output of
//   a pipelined datapath stage.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, empties the line
//   clr   : synchronous clear, empties the line (wins over din)
//   din   : valid bit entering the line
//   dout  : din delayed by DEPTH cycles (DEPTH >= 1)
module softmax_vld_delay #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr <= '0;
      end else if (clr) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/softmax_seq.sv
// softmax_seq
//   Central sequencer for the softmax datapath. Walks the three memory read
//   ports (max, sub/exp/sum, presub/logsub/exp) in order and emits the stage
//   enables and clears aligned to the fixed datapath latencies.
//   clk, reset          : clock / asynchronous active-low reset
//   start, abort        : run request (IDLE only) / synchronous abort
//   start_addr,end_addr : inclusive data range, latched on accepted start
//   busy, done, err     : status; done and err are one-cycle pulses
//   addr/sub0/sub1      : read addresses + valids for the three ports
//   max_clr/en, sum_clr/en, ln_en, out_vld : datapath stage controls
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for start
//   MAX_RD    | streaming addresses to the max tree port
//   MAX_DRAIN | waiting for the last element to leave the max tree
//   SUB_RD    | streaming addresses to the sub/exp/sum port
//   SUM_DRAIN | waiting for the last element to leave the adder tree
//   LOG       | ln of the sum is computed and latched
//   OUT_RD    | streaming addresses to the presub/logsub/exp port
//   OUT_DRAIN | waiting for the last output to leave the exp stage
//   DONE      | one-cycle completion, done pulse
module softmax_seq
   import softmax_seq_pkg::*;
#(
   parameter int ADDRSIZE = DEF_ADDRSIZE,
   parameter int RD_LAT   = DEF_RD_LAT,
   parameter int MAX_LAT  = DEF_MAX_LAT,
   parameter int EXP_LAT  = DEF_EXP_LAT,
   parameter int SUM_LAT  = DEF_SUM_LAT,
   parameter int LN_LAT   = DEF_LN_LAT,
   parameter int OUT_LAT  = DEF_OUT_LAT,
   parameter int CW       = DEF_CW
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDRSIZE-1:0] start_addr,
   input  logic [ADDRSIZE-1:0] end_addr,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDRSIZE-1:0] addr,
   output logic                addr_vld,
   output logic [ADDRSIZE-1:0] sub0_addr,
   output logic                sub0_vld,
   output logic [ADDRSIZE-1:0] sub1_addr,
   output logic                sub1_vld,
   output logic                max_clr,
   output logic                max_en,
   output logic                sum_clr,
   output logic                sum_en,
   output logic                ln_en,
   output logic                out_vld
);

   // Counter loads are length-1 because the state exits in the cycle the
   // counter reads zero.
   localparam logic [CW-1:0] MAX_LOAD = CW'(RD_LAT + MAX_LAT - 1);
   localparam logic [CW-1:0] SUM_LOAD = CW'(RD_LAT + EXP_LAT + SUM_LAT - 1);
   localparam logic [CW-1:0] LN_LOAD  = CW'(LN_LAT - 1);
   localparam logic [CW-1:0] OUT_LOAD = CW'(RD_LAT + OUT_LAT - 1);

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [ADDRSIZE-1:0] start_q, start_q_nxt;
   logic [ADDRSIZE-1:0] end_q, end_q_nxt;
   logic [ADDRSIZE-1:0] addr_nxt, sub0_addr_nxt, sub1_addr_nxt;
   logic                addr_vld_nxt, sub0_vld_nxt, sub1_vld_nxt;
   logic                max_clr_nxt, sum_clr_nxt, ln_en_nxt;
   logic                done_nxt, err_nxt, busy_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         start_q   <= '0;
         end_q     <= '0;
         addr      <= '0;
         sub0_addr <= '0;
         sub1_addr <= '0;
         addr_vld  <= 1'b0;
         sub0_vld  <= 1'b0;
         sub1_vld  <= 1'b0;
         max_clr   <= 1'b0;
         sum_clr   <= 1'b0;
         ln_en     <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         start_q   <= start_q_nxt;
         end_q     <= end_q_nxt;
         addr      <= addr_nxt;
         sub0_addr <= sub0_addr_nxt;
         sub1_addr <= sub1_addr_nxt;
         addr_vld  <= addr_vld_nxt;
         sub0_vld  <= sub0_vld_nxt;
         sub1_vld  <= sub1_vld_nxt;
         max_clr   <= max_clr_nxt;
         sum_clr   <= sum_clr_nxt;
         ln_en     <= ln_en_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = (cnt != '0) ? cnt - 1'b1 : cnt;
      start_q_nxt   = start_q;
      end_q_nxt     = end_q;
      addr_nxt      = addr;
      sub0_addr_nxt = sub0_addr;
      sub1_addr_nxt = sub1_addr;
      addr_vld_nxt  = 1'b0;
      sub0_vld_nxt  = 1'b0;
      sub1_vld_nxt  = 1'b0;
      max_clr_nxt   = 1'b0;
      sum_clr_nxt   = 1'b0;
      ln_en_nxt     = 1'b0;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (end_addr >= start_addr) begin
                  start_q_nxt  = start_addr;
                  end_q_nxt    = end_addr;
                  addr_nxt     = start_addr;
                  addr_vld_nxt = 1'b1;
                  max_clr_nxt  = 1'b1;
                  state_nxt    = MAX_RD;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         // Read states stop on equality with the latched end address, so an
         // end of all-ones never needs the counter to wrap.
         MAX_RD: begin
            if (addr == end_q) begin
               cnt_nxt   = MAX_LOAD;
               state_nxt = MAX_DRAIN;
            end else begin
               addr_nxt     = addr + 1'b1;
               addr_vld_nxt = 1'b1;
            end
         end
         MAX_DRAIN: begin
            if (cnt == '0) begin
               sub0_addr_nxt = start_q;
               sub0_vld_nxt  = 1'b1;
               sum_clr_nxt   = 1'b1;
               state_nxt     = SUB_RD;
            end
         end
         SUB_RD: begin
            if (sub0_addr == end_q) begin
               cnt_nxt   = SUM_LOAD;
               state_nxt = SUM_DRAIN;
            end else begin
               sub0_addr_nxt = sub0_addr + 1'b1;
               sub0_vld_nxt  = 1'b1;
            end
         end
         SUM_DRAIN: begin
            if (cnt == '0) begin
               cnt_nxt   = LN_LOAD;
               ln_en_nxt = 1'b1;
               state_nxt = LOG;
            end
         end
         LOG: begin
            if (cnt == '0) begin
               sub1_addr_nxt = start_q;
               sub1_vld_nxt  = 1'b1;
               state_nxt     = OUT_RD;
            end
         end
         OUT_RD: begin
            if (sub1_addr == end_q) begin
               cnt_nxt   = OUT_LOAD;
               state_nxt = OUT_DRAIN;
            end else begin
               sub1_addr_nxt = sub1_addr + 1'b1;
               sub1_vld_nxt  = 1'b1;
            end
         end
         OUT_DRAIN: begin
            if (cnt == '0) begin
               done_nxt  = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Abort overrides everything above, including a same-cycle start.
      if (abort) begin
         state_nxt     = IDLE;
         cnt_nxt       = '0;
         addr_nxt      = '0;
         sub0_addr_nxt = '0;
         sub1_addr_nxt = '0;
         addr_vld_nxt  = 1'b0;
         sub0_vld_nxt  = 1'b0;
         sub1_vld_nxt  = 1'b0;
         max_clr_nxt   = 1'b0;
         sum_clr_nxt   = 1'b0;
         ln_en_nxt     = 1'b0;
         done_nxt      = 1'b0;
         err_nxt       = 1'b0;
      end

      busy_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
   end

   softmax_vld_delay #(.DEPTH(RD_LAT)) u_max_dly (
      .clk  (clk),
      .reset(reset),
      .clr  (abort),
      .din  (addr_vld),
      .dout (max_en)
   );

   softmax_vld_delay #(.DEPTH(RD_LAT + EXP_LAT)) u_sum_dly (
      .clk  (clk),
      .reset(reset),
      .clr  (abort),
      .din  (sub0_vld),
      .dout (sum_en)
   );

   softmax_vld_delay #(.DEPTH(RD_LAT + OUT_LAT)) u_out_dly (
      .clk  (clk),
      .reset(reset),
      .clr  (abort),
      .din  (sub1_vld),
      .dout (out_vld)
   );

endmodule

// File: tb/tb_softmax_seq.sv
// tb_softmax_seq
//   Bench for softmax_seq: directed cases plus randomized runs, each cycle
//   compared against a schedule derived from the range length and latencies.
module tb_softmax_seq;

   localparam int AW = 8;
   localparam int RD = 1;
   localparam int MX = 2;
   localparam int EX = 1;
   localparam int SM = 2;
   localparam int LN = 1;
   localparam int OL = 3;
   localparam int CWID = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic          busy, done, err;
   logic [AW-1:0] addr, sub0_addr, sub1_addr;
   logic          addr_vld, sub0_vld, sub1_vld;
   logic          max_clr, max_en, sum_clr, sum_en, ln_en, out_vld;

   int total = 0;
   int bad = 0;

   softmax_seq #(
      .ADDRSIZE(AW), .RD_LAT(RD), .MAX_LAT(MX), .EXP_LAT(EX),
      .SUM_LAT(SM), .LN_LAT(LN), .OUT_LAT(OL), .CW(CWID)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .start_addr(start_addr), .end_addr(end_addr),
      .busy(busy), .done(done), .err(err),
      .addr(addr), .addr_vld(addr_vld),
      .sub0_addr(sub0_addr), .sub0_vld(sub0_vld),
      .sub1_addr(sub1_addr), .sub1_vld(sub1_vld),
      .max_clr(max_clr), .max_en(max_en),
      .sum_clr(sum_clr), .sum_en(sum_en),
      .ln_en(ln_en), .out_vld(out_vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // bit order: busy done err addr_vld sub0_vld sub1_vld max_clr max_en
   //            sum_clr sum_en ln_en out_vld
   function automatic logic [11:0] flags_now();
      return {busy, done, err, addr_vld, sub0_vld, sub1_vld,
              max_clr, max_en, sum_clr, sum_en, ln_en, out_vld};
   endfunction

   // Phase start cycles for a run of n elements whose start was sampled at
   // the end of cycle 0.
   function automatic int sub_start(int n);
      return n + RD + MX + 1;
   endfunction

   function automatic int log_cycle(int n);
      return sub_start(n) + n + RD + EX + SM;
   endfunction

   function automatic int out_start(int n);
      return log_cycle(n) + LN;
   endfunction

   function automatic int done_cycle(int n);
      return out_start(n) + n + RD + OL;
   endfunction

   function automatic logic [11:0] exp_flags(int c, int s, int e, int ab);
      int n, s0, l0, o0, d0;
      logic b, d, av, s0v, s1v, mc, me, sc, se, le, ov;
      if (ab >= 0 && c > ab) return '0;
      if (e < s) return (c == 1) ? 12'h200 : 12'h000;
      n   = e - s + 1;
      s0  = sub_start(n);
      l0  = log_cycle(n);
      o0  = out_start(n);
      d0  = done_cycle(n);
      b   = (c >= 1) && (c < d0);
      d   = (c == d0);
      av  = (c >= 1) && (c <= n);
      s0v = (c >= s0) && (c < s0 + n);
      s1v = (c >= o0) && (c < o0 + n);
      mc  = (c == 1);
      me  = (c >= 1 + RD) && (c <= n + RD);
      sc  = (c == s0);
      se  = (c >= s0 + RD + EX) && (c < s0 + n + RD + EX);
      le  = (c == l0);
      ov  = (c >= o0 + RD + OL) && (c < o0 + n + RD + OL);
      return {b, d, 1'b0, av, s0v, s1v, mc, me, sc, se, le, ov};
   endfunction

   // One run: start in cycle 0, compare every following cycle. ab>=0 aborts
   // in that cycle; hold keeps start high (with junk ranges) until done;
   // rc>=0 pulses reset asynchronously during that cycle.
   task automatic run(input int s, input int e, input int ab, input int hold, input int rc);
      int n, d0, tmax;
      logic [11:0] ef;
      n    = (e >= s) ? e - s + 1 : 0;
      d0   = done_cycle(n);
      tmax = (e < s) ? 4 : ((ab >= 0) ? ab + 4 : d0 + 2);
      chk("idle_before", {20'h0, flags_now()}, 32'h0);
      start_addr = AW'(s);
      end_addr   = AW'(e);
      start      = 1'b1;
      abort      = 1'b0;
      for (int c = 1; c <= tmax; c++) begin
         @(posedge clk);
         #1;
         ef = exp_flags(c, s, e, ab);
         chk("flags", {20'h0, flags_now()}, {20'h0, ef});
         if (ef[8]) chk("addr", {24'h0, addr}, (s + c - 1) & 255);
         if (ef[7]) chk("sub0_addr", {24'h0, sub0_addr}, (s + c - sub_start(n)) & 255);
         if (ef[6]) chk("sub1_addr", {24'h0, sub1_addr}, (s + c - out_start(n)) & 255);
         if (ab >= 0 && c == ab + 1)
            chk("abort_addr", {8'h0, addr, sub0_addr, sub1_addr}, 32'h0);
         if (c == rc) begin
            #2;
            reset = 1'b0;
            start = 1'b0;
            #1;
            chk("rst_flags", {20'h0, flags_now()}, 32'h0);
            chk("rst_addr", {8'h0, addr, sub0_addr, sub1_addr}, 32'h0);
            @(posedge clk);
            #1;
            chk("rst_hold", {20'h0, flags_now()}, 32'h0);
            reset = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(posedge clk);
               #1;
               chk("post_rst", {20'h0, flags_now()}, 32'h0);
            end
            return;
         end
         start = (hold != 0) && (c <= d0);
         abort = (c == ab);
         if (hold != 0) begin
            start_addr = AW'($urandom);
            end_addr   = AW'($urandom);
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "bench timed out");
   end

   initial begin
      int s, e, ab, sel, n;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_flags", {20'h0, flags_now()}, 32'h0);
      chk("reset_addr", {8'h0, addr, sub0_addr, sub1_addr}, 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run(8'h10, 8'h13, -1, 0, -1);   // nominal
      run(8'h05, 8'h05, -1, 0, -1);   // single element
      run(8'h08, 8'h07, -1, 0, -1);   // bad range
      run(8'hFE, 8'hFF, -1, 0, -1);   // top of address space
      run(8'h10, 8'h13,  9, 0, -1);   // abort in SUB_RD
      run(8'h30, 8'h33, -1, 0, -1);   // accepted after abort

      // start and abort together in IDLE: nothing starts
      start_addr = 8'h11;
      end_addr   = 8'h12;
      start      = 1'b1;
      abort      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("abort_start", {20'h0, flags_now()}, 32'h0);
         @(posedge clk);
         #1;
      end

      run(8'h20, 8'h27, -1, 0, 27);   // async reset during OUT_RD
      run(8'h40, 8'h42, -1, 1, -1);   // start held through the run

      for (int i = 0; i < 25; i++) begin
         s   = int'($urandom_range(0, 255));
         sel = int'($urandom_range(0, 9));
         if (sel == 0 && s > 0) begin
            e = int'($urandom_range(0, s - 1));
         end else begin
            n = int'($urandom_range(1, 12));
            e = (s + n - 1 > 255) ? 255 : s + n - 1;
         end
         ab = -1;
         if (sel >= 8 && e >= s) ab = int'($urandom_range(1, done_cycle(e - s + 1) - 1));
         run(s, e, ab, (sel == 7) ? 1 : 0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
